// File: rtl/tdm_demux2_if.sv
// Link-side bundle for the 2:1 TDM receiver: serial data/sync in, rebuilt words and status out.
// The link is free-running with one slot per clock, so there is no backpressure.
interface tdm_demux2_if #(parameter int W = 4);
    logic         d;
    logic         sync;
    logic [W-1:0] a_word;
    logic [W-1:0] b_word;
    logic         valid;
    logic         s;
    logic         err;

    modport master (
        output d, sync,
        input  a_word, b_word, valid, s, err
    );

    modport slave (
        input  d, sync,
        output a_word, b_word, valid, s, err
    );
endinterface

// File: rtl/tdm_demux2.sv
// 2:1 TDM receiver: even slots build channel a and odd slots build channel b, LSB first.
// Words and valid update on the edge that samples slot 2W-1; there is no backpressure.
module tdm_demux2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux2_if.slave  bus
);
    localparam int            SW   = $clog2(2 * W);
    localparam logic [SW-1:0] LAST = SW'(2 * W - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state;
    logic [SW-1:0] slot;
    logic [SW-2:0] pos;
    logic [W-1:0]  sh_a, sh_b;
    logic [W-1:0]  a_word_q, b_word_q;
    logic          valid_q, err_q, s_q;

    // Slot k carries bit k/2 of its channel.
    assign pos = slot[SW-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            slot     <= '0;
            sh_a     <= '0;
            sh_b     <= '0;
            a_word_q <= '0;
            b_word_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            s_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sync) begin
                        sh_a  <= W'(bus.d);
                        sh_b  <= '0;
                        slot  <= SW'(1);
                        state <= RECV;
                        s_q   <= 1'b1;
                    end else begin
                        s_q   <= 1'b0;
                    end
                end
                RECV: begin
                    if (bus.sync) begin
                        // Early sync: drop the partial frame and restart from this slot 0.
                        err_q <= 1'b1;
                        sh_a  <= W'(bus.d);
                        sh_b  <= '0;
                        slot  <= SW'(1);
                        s_q   <= 1'b1;
                    end else if (slot == LAST) begin
                        a_word_q <= sh_a;
                        b_word_q <= {bus.d, sh_b[W-2:0]};
                        valid_q  <= 1'b1;
                        sh_a     <= '0;
                        sh_b     <= '0;
                        slot     <= '0;
                        state    <= IDLE;
                        s_q      <= 1'b0;
                    end else begin
                        if (slot[0])
                            sh_b[pos] <= bus.d;
                        else
                            sh_a[pos] <= bus.d;
                        slot <= slot + SW'(1);
                        s_q  <= ~slot[0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_word = a_word_q;
    assign bus.b_word = b_word_q;
    assign bus.valid  = valid_q;
    assign bus.err    = err_q;
    assign bus.s      = s_q;
endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2 at W=4 with hand-computed frame words.
module tb_tdm_demux2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    tdm_demux2_if #(.W(4)) bus ();

    tdm_demux2 #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one slot, let the edge sample it, then look at outputs 1ns later.
    task automatic send(input logic dv, input logic sv);
        bus.d    = dv;
        bus.sync = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a"}, 32'(bus.a_word), 32'h0);
        chk({tag, "_b"}, 32'(bus.b_word), 32'h0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
        chk({tag, "_err"}, 32'(bus.err), 32'h0);
        chk({tag, "_s"}, 32'(bus.s), 32'h0);
    endtask

    // bits[k] is the value sent in slot k; sync accompanies slot 0.
    task automatic send_frame(input string tag, input logic [7:0] bits,
                              input logic [3:0] ea, input logic [3:0] eb);
        for (int k = 0; k < 8; k++) begin
            send(bits[k], k == 0);
            chk({tag, "_s"}, 32'(bus.s), (k == 7) ? 32'h0 : 32'((k + 1) % 2));
            chk({tag, "_valid"}, 32'(bus.valid), (k == 7) ? 32'h1 : 32'h0);
            chk({tag, "_err"}, 32'(bus.err), 32'h0);
        end
        chk({tag, "_a"}, 32'(bus.a_word), 32'(ea));
        chk({tag, "_b"}, 32'(bus.b_word), 32'(eb));
    endtask

    initial begin
        bus.d    = 1'b0;
        bus.sync = 1'b0;
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No sync: d must be ignored entirely.
        for (int i = 0; i < 20; i++) begin
            send(i[0], 1'b0);
            chk("idle_out", {25'h0, bus.valid, bus.err, bus.s, bus.a_word | bus.b_word},
                32'h0);
        end

        // 0,1,1,0,0,1,1,0 -> a=A, b=5
        send_frame("f1", 8'h66, 4'hA, 4'h5);
        // Back-to-back: 1,1,1,1,0,0,0,0 -> a=3, b=3; first slot checks valid drops
        send_frame("f2", 8'h0F, 4'h3, 4'h3);
        send(1'b0, 1'b0);
        chk("f2_valid_drop", 32'(bus.valid), 32'h0);

        // Good frame, then early sync at slot 3 of the next one.
        send_frame("f3", 8'h66, 4'hA, 4'h5);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        chk("abort_err", 32'(bus.err), 32'h1);
        chk("abort_valid", 32'(bus.valid), 32'h0);
        chk("abort_a", 32'(bus.a_word), 32'hA);
        chk("abort_b", 32'(bus.b_word), 32'h5);
        chk("abort_s", 32'(bus.s), 32'h1);
        begin
            logic [7:0] fb;
            fb = 8'h0F;
            for (int k = 1; k < 8; k++) begin
                send(fb[k], 1'b0);
                chk("restart_err", 32'(bus.err), 32'h0);
                chk("restart_valid", 32'(bus.valid), (k == 7) ? 32'h1 : 32'h0);
            end
        end
        chk("restart_a", 32'(bus.a_word), 32'h3);
        chk("restart_b", 32'(bus.b_word), 32'h3);

        // Reset mid-frame after slots 0..4 of a new frame.
        begin
            logic [7:0] fb;
            fb = 8'h66;
            for (int k = 0; k < 5; k++) send(fb[k], k == 0);
        end
        chk("pre_rst_s", 32'(bus.s), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0);
            chk("post_rst_idle", {28'h0, bus.valid, bus.err, bus.s, |bus.a_word}, 32'h0);
        end
        send_frame("f4", 8'h66, 4'hA, 4'h5);
        send(1'b0, 1'b0);
        chk("f4_hold_a", 32'(bus.a_word), 32'hA);
        chk("f4_hold_b", 32'(bus.b_word), 32'h5);
        chk("f4_idle_s", 32'(bus.s), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
